// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the ROM, buffers {pc, instr} in a 2-entry prefetch queue.
// Latency: a push is visible at the head one cycle later when the queue was empty; a redirect takes two cycles to reach the head.
// Backpressure: a full queue with no pop stops pushing and holds the PC; out_ready only pops entries.
module fetch_unit #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int unsigned                DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [1:0]               occupancy
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0]   instr;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  entry_t                   head;
  entry_t                   tail;
  entry_t                   new_entry;
  logic                     push;
  logic                     pop;
  logic                     unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};
  assign redirect_target      = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};

  assign imem_addr = pc;
  assign new_entry = '{pc: pc, instr: imem_instr};

  assign out_valid = (occupancy != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & ((occupancy != FULL) | pop);

  // Head is only rewritten when a real entry lands there, so an empty
  // queue keeps presenting its last (or reset) contents rather than stale tail data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      occupancy <= 2'd0;
      head      <= '0;
      tail      <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_target;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        pc <= pc + ADDRESS_WIDTH'(4);
      end
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) begin
            head <= new_entry;
          end else begin
            tail <= new_entry;
          end
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          if (occupancy == FULL) begin
            head <= tail;
          end
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          if (occupancy == 2'd1) begin
            head <= new_entry;
          end else begin
            head <= tail;
            tail <= new_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a ROM model feeds the DUT, every accepted output is checked
// against a queue of expected {pc, instr} pairs, and each scenario checks its own timing.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  occupancy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_unit #(
    .ADDRESS_WIDTH(32),
    .INSTR_WIDTH  (32),
    .RESET_PC     (32'h0000_0000),
    .DEPTH        (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .occupancy     (occupancy)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_instr = rom(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  // Scoreboard: inputs change 1 time unit after posedge, so the handshake is stable here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got pc=%h instr=%h, required no output", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++;
          $display("FAIL sb_output: got pc=%h instr=%h, required pc=%h instr=%h",
                   out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic drive(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en       = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] a);
    exp_q.push_back('{pc: a, instr: rom(a)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    n_checks++;
    if (imem_addr !== 32'h0 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got addr=%h valid=%b occ=%0d, required 0/0/0", imem_addr, out_valid, occupancy);
    end
    n_checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got pc=%h instr=%h, required 0/0", out_pc, out_instr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) expect_pc(32'(4 * k));
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) drive(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_head%0d: got valid=%b pc=%h occ=%0d, required 1/%h/1",
                 k, out_valid, out_pc, occupancy, 32'(4 * k));
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_drain: got valid=%b occ=%0d, required 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 2) begin
        n_checks++;
        if (occupancy !== 2'd2 || imem_addr !== 32'h8 || out_pc !== 32'h0 || out_instr !== rom(32'h0)) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got occ=%0d addr=%h pc=%h instr=%h, required 2/8/0/%h",
                   k, occupancy, imem_addr, out_pc, out_instr, rom(32'h0));
        end
      end
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (out_pc !== 32'h4 || occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL stall_resume: got pc=%h occ=%0d, required 4/2", out_pc, occupancy);
    end
    tick();
    n_checks++;
    if (out_pc !== 32'h8 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_next: got pc=%h occ=%0d, required 8/1", out_pc, occupancy);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    tick();
    tick();
    n_checks++;
    if (imem_addr !== 32'h8 || out_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL redir_pre: got addr=%h pc=%h, required 8/4", imem_addr, out_pc);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_flush: got valid=%b addr=%h, required 0/100", out_valid, imem_addr);
    end
    expect_pc(32'h100);
    expect_pc(32'h104);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_target: got valid=%b pc=%h, required 1/100", out_valid, out_pc);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_redirect_pop_full();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL rpf_full: got occ=%0d, required 2", occupancy);
    end
    expect_pc(32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rpf_flush: got occ=%0d valid=%b addr=%h, required 0/0/40", occupancy, out_valid, imem_addr);
    end
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rpf_idle: got occ=%0d addr=%h, required 0/40", occupancy, imem_addr);
    end
    expect_pc(32'h40);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4];
    seq[0] = 32'hFFFF_FFF8;
    seq[1] = 32'hFFFF_FFFC;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0004;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFF8 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_load: got addr=%h valid=%b, required fffffff8/0", imem_addr, out_valid);
    end
    for (int k = 0; k < 4; k++) expect_pc(seq[k]);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) drive(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++;
      if (out_pc !== seq[k]) begin
        n_fail++;
        $display("FAIL wrap_pc%0d: got pc=%h, required %h", k, out_pc, seq[k]);
      end
    end
    n_checks++;
    if (imem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL wrap_addr: got addr=%h, required 8", imem_addr);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_clear: got occ=%0d valid=%b addr=%h, required 0/0/0", occupancy, out_valid, imem_addr);
    end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_restart: got valid=%b pc=%h, required 1/0", out_valid, out_pc);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop_full();
    test_wrap();
    test_async_reset();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending outputs, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
